// File: rtl/sisp_alu_issue.sv
// Operand-issue / write-back stage in front of the SISP no-buffer ALU: IDLE -> EXEC -> WB.
// Define SISP_WB_SAT_EN to clamp the written-back byte; otherwise the result is truncated.
module sisp_alu_issue #(
    parameter int REG_NUM = 8,
    parameter int ADDR_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_src_a,
    input  logic [ADDR_W-1:0] cmd_src_b,
    input  logic              cmd_imm_sel,
    input  logic [7:0]        cmd_imm,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic              cmd_wb_en,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    output logic [7:0]        alu_data_1,
    output logic [7:0]        alu_data_2,
    output logic              alu_input_select,
    output logic [7:0]        alu_content,
    output logic [3:0]        alu_selector,
    output logic              alu_enable,
    input  logic [15:0]       alu_result,
    output logic              res_valid,
    output logic [15:0]       res_data,
    output logic [7:0]        res_wdata,
    output logic [ADDR_W-1:0] res_dst,
    output logic              res_illegal,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [3:0]        op_reg;
    logic [ADDR_W-1:0] src_a_reg;
    logic [ADDR_W-1:0] src_b_reg;
    logic [ADDR_W-1:0] dst_reg;
    logic              imm_sel_reg;
    logic [7:0]        imm_reg;
    logic              wb_en_reg;

    logic [15:0]       res_data_reg;
    logic [7:0]        res_wdata_reg;
    logic [ADDR_W-1:0] res_dst_reg;
    logic              res_illegal_reg;

    logic [7:0]        rf_word [REG_NUM];
    logic              accept;
    logic              wb_write;
    logic              op_illegal;
    logic [7:0]        wdata_next;

    assign cmd_ready = reset && (state_reg != EXEC);
    assign accept    = cmd_valid && cmd_ready;
    assign wb_write  = (state_reg == WB) && wb_en_reg && !res_illegal_reg;

    assign res_valid   = (state_reg == WB);
    assign busy        = (state_reg != IDLE);
    assign res_data    = res_data_reg;
    assign res_wdata   = res_wdata_reg;
    assign res_dst     = res_dst_reg;
    assign res_illegal = res_illegal_reg;

    always_comb begin
        op_illegal = 1'b1;
        case (op_reg)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd8, 4'd9: op_illegal = 1'b0;
            default: op_illegal = 1'b1;
        endcase
    end

`ifdef SISP_WB_SAT_EN
    // Add saturates high; the subtracting ops floor at zero on a negative result.
    always_comb begin
        wdata_next = alu_result[7:0];
        if (op_reg == 4'd2 && alu_result > 16'd255)
            wdata_next = 8'hFF;
        else if ((op_reg == 4'd3 || op_reg == 4'd5) && alu_result[15])
            wdata_next = 8'h00;
    end
`else
    assign wdata_next = alu_result[7:0];
`endif

    always_comb begin
        state_next       = state_reg;
        alu_enable       = 1'b0;
        alu_data_1       = 8'd0;
        alu_data_2       = 8'd0;
        alu_content      = 8'd0;
        alu_input_select = 1'b0;
        alu_selector     = 4'd0;
        case (state_reg)
            IDLE: begin
                if (accept)
                    state_next = EXEC;
            end
            EXEC: begin
                alu_enable       = 1'b1;
                alu_data_1       = rf_word[src_a_reg];
                alu_data_2       = rf_word[src_b_reg];
                alu_content      = imm_reg;
                alu_input_select = imm_sel_reg;
                alu_selector     = op_reg;
                state_next       = WB;
            end
            WB: begin
                state_next = accept ? EXEC : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= IDLE;
            op_reg          <= 4'd0;
            src_a_reg       <= '0;
            src_b_reg       <= '0;
            dst_reg         <= '0;
            imm_sel_reg     <= 1'b0;
            imm_reg         <= 8'd0;
            wb_en_reg       <= 1'b0;
            res_data_reg    <= 16'd0;
            res_wdata_reg   <= 8'd0;
            res_dst_reg     <= '0;
            res_illegal_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                op_reg      <= cmd_op;
                src_a_reg   <= cmd_src_a;
                src_b_reg   <= cmd_src_b;
                dst_reg     <= cmd_dst;
                imm_sel_reg <= cmd_imm_sel;
                imm_reg     <= cmd_imm;
                wb_en_reg   <= cmd_wb_en;
            end
            if (state_reg == EXEC) begin
                res_data_reg    <= alu_result;
                res_wdata_reg   <= wdata_next;
                res_dst_reg     <= dst_reg;
                res_illegal_reg <= op_illegal;
            end
        end
    end

    // Write-back takes priority over an external load to the same register.
    generate
        for (genvar gi = 0; gi < REG_NUM; gi++) begin : g_rf
            logic [7:0] entry_reg;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset)
                    entry_reg <= 8'd0;
                else if (wb_write && res_dst_reg == ADDR_W'(gi))
                    entry_reg <= res_wdata_reg;
                else if (ld_en && ld_addr == ADDR_W'(gi))
                    entry_reg <= ld_data;
            end
            assign rf_word[gi] = entry_reg;
        end
    endgenerate

endmodule

// File: tb/tb_sisp_alu_issue.sv
// Scoreboard bench for sisp_alu_issue: a behavioural ALU answers the DUT's drive, a register model predicts results.
module tb_sisp_alu_issue;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_op = 4'd0;
    logic [2:0]  cmd_src_a = 3'd0;
    logic [2:0]  cmd_src_b = 3'd0;
    logic        cmd_imm_sel = 1'b0;
    logic [7:0]  cmd_imm = 8'd0;
    logic [2:0]  cmd_dst = 3'd0;
    logic        cmd_wb_en = 1'b0;
    logic        ld_en = 1'b0;
    logic [2:0]  ld_addr = 3'd0;
    logic [7:0]  ld_data = 8'd0;
    logic [7:0]  alu_data_1, alu_data_2, alu_content;
    logic        alu_input_select, alu_enable;
    logic [3:0]  alu_selector;
    logic [15:0] alu_result;
    logic        res_valid, res_illegal, busy;
    logic [15:0] res_data;
    logic [7:0]  res_wdata;
    logic [2:0]  res_dst;

    int checks = 0;
    int errors = 0;
    int neg_cnt = 0;

    typedef struct {
        logic [7:0]  a, b, imm;
        logic        isel;
        logic [3:0]  op;
        logic [15:0] res;
        logic [7:0]  wdata;
        logic [2:0]  dst;
        logic        illegal, wb_en;
        int          exec_neg, wb_neg;
    } exp_t;

    exp_t       q[$];
    logic [7:0] mreg [8];
    exp_t       exec_e, wb_e;
    bit         exec_v = 0;
    bit         wb_v = 0;

    sisp_alu_issue #(.REG_NUM(8), .ADDR_W(3)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_imm_sel(cmd_imm_sel),
        .cmd_imm(cmd_imm), .cmd_dst(cmd_dst), .cmd_wb_en(cmd_wb_en),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .alu_data_1(alu_data_1), .alu_data_2(alu_data_2),
        .alu_input_select(alu_input_select), .alu_content(alu_content),
        .alu_selector(alu_selector), .alu_enable(alu_enable), .alu_result(alu_result),
        .res_valid(res_valid), .res_data(res_data), .res_wdata(res_wdata),
        .res_dst(res_dst), .res_illegal(res_illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: plain integer arithmetic on the selected operands.
    function automatic logic [15:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int d;
        d = int'(a) - int'(b);
        case (op)
            4'd0: return {8'd0, a & b};
            4'd1: return {8'd0, a | b};
            4'd2: return 16'(int'(a) + int'(b));
            4'd3: return 16'(d >>> 1);
            4'd4: return 16'((d < 0) ? -d : d);
            4'd5: return 16'(d);
            4'd8: return {8'd0, (a < b) ? a : b};
            4'd9: return {8'd0, (a > b) ? a : b};
            default: return 16'd0;
        endcase
    endfunction

    function automatic logic [7:0] wb_value(input logic [3:0] op, input logic [15:0] r);
`ifdef SISP_WB_SAT_EN
        if (op == 4'd2 && r > 16'd255) return 8'd255;
        if ((op == 4'd3 || op == 4'd5) && r[15]) return 8'd0;
`endif
        return r[7:0];
    endfunction

    assign alu_result = alu_enable ?
        alu_fn(alu_selector, alu_data_1, alu_input_select ? alu_content : alu_data_2) : 16'd0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor: compares whatever the DUT presents against the scoreboard front.
    always @(negedge clk) begin
        bit is_exec, is_wb;
        neg_cnt++;
        if (reset) begin
            is_exec = (q.size() > 0) && (q[0].exec_neg == neg_cnt);
            is_wb   = (q.size() > 0) && (q[0].wb_neg == neg_cnt);
            if (is_exec) begin
                check("alu_enable", alu_enable, 1);
                check("alu_data_1", alu_data_1, q[0].a);
                check("alu_data_2", alu_data_2, q[0].b);
                check("alu_content", alu_content, q[0].imm);
                check("alu_input_select", alu_input_select, q[0].isel);
                check("alu_selector", alu_selector, q[0].op);
            end else begin
                check("alu_idle_drive", {alu_enable, alu_input_select, alu_selector,
                                         alu_data_1, alu_data_2, alu_content}, 0);
            end
            if (is_wb) begin
                $display("result op=%0d dst=%0d data=%04h wdata=%02h illegal=%0d",
                         q[0].op, q[0].dst, res_data, res_wdata, res_illegal);
                check("res_valid", res_valid, 1);
                check("res_data", res_data, q[0].res);
                check("res_wdata", res_wdata, q[0].wdata);
                check("res_dst", res_dst, q[0].dst);
                check("res_illegal", res_illegal, q[0].illegal);
                void'(q.pop_front());
            end else if (res_valid) begin
                check("res_valid_unexpected", res_valid, 0);
            end
            check("busy", busy, (is_exec || is_wb) ? 1 : 0);
        end
    end

    // One clock of stimulus; the register model is advanced at the edge.
    task automatic step(output bit hs);
        bit rdy;
        rdy = !exec_v;
        check("cmd_ready", cmd_ready, rdy);
        hs = cmd_valid && rdy;
        @(posedge clk);
        if (ld_en) mreg[ld_addr] = ld_data;
        if (wb_v && wb_e.wb_en && !wb_e.illegal) mreg[wb_e.dst] = wb_e.wdata;
        wb_v = exec_v;
        wb_e = exec_e;
        exec_v = hs;
        if (hs) begin
            exec_e.a        = mreg[cmd_src_a];
            exec_e.b        = mreg[cmd_src_b];
            exec_e.imm      = cmd_imm;
            exec_e.isel     = cmd_imm_sel;
            exec_e.op       = cmd_op;
            exec_e.res      = alu_fn(cmd_op, exec_e.a, cmd_imm_sel ? cmd_imm : exec_e.b);
            exec_e.illegal  = !(cmd_op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd8, 4'd9});
            exec_e.wdata    = wb_value(cmd_op, exec_e.res);
            exec_e.dst      = cmd_dst;
            exec_e.wb_en    = cmd_wb_en;
            exec_e.exec_neg = neg_cnt + 1;
            exec_e.wb_neg   = neg_cnt + 2;
            q.push_back(exec_e);
        end
        #1;
    endtask

    task automatic idle(input int n);
        bit hs;
        cmd_valid = 1'b0;
        ld_en = 1'b0;
        repeat (n) step(hs);
    endtask

    task automatic load(input logic [2:0] addr, input logic [7:0] data);
        bit hs;
        cmd_valid = 1'b0;
        ld_en = 1'b1; ld_addr = addr; ld_data = data;
        step(hs);
        ld_en = 1'b0;
    endtask

    task automatic issue(input logic [3:0] op, input logic [2:0] a, input logic [2:0] b,
                         input logic isel, input logic [7:0] imm, input logic [2:0] dst,
                         input logic wb, output int waited);
        bit hs;
        cmd_valid = 1'b1; cmd_op = op; cmd_src_a = a; cmd_src_b = b;
        cmd_imm_sel = isel; cmd_imm = imm; cmd_dst = dst; cmd_wb_en = wb;
        ld_en = 1'b0;
        waited = 0;
        hs = 0;
        while (!hs && waited < 8) begin
            step(hs);
            waited++;
        end
        if (!hs) check("issue_timeout", 0, 1);
    endtask

    task automatic readback_all();
        int w;
        for (int r = 0; r < 8; r++) begin
            issue(4'd0, 3'(r), 3'd0, 1'b1, 8'hFF, 3'd0, 1'b0, w);
            idle(2);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        bit hs;
        logic [3:0] legal_ops [8];
        legal_ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd8, 4'd9};
        for (int i = 0; i < 8; i++) mreg[i] = 8'd0;

        #1 reset = 1'b0;
        #2;
        check("reset_res", {res_valid, res_data, res_wdata, res_dst, res_illegal, busy}, 0);
        check("reset_alu", {alu_enable, alu_input_select, alu_selector,
                            alu_data_1, alu_data_2, alu_content}, 0);
        #9 reset = 1'b1;
        @(posedge clk); #1;

        // Add with overflow past 255
        load(3'd1, 8'd200); load(3'd2, 8'd100);
        issue(4'd2, 3'd1, 3'd2, 1'b0, 8'd0, 3'd3, 1'b1, w);
        idle(3);
        // Sub going negative, then Abs_Sub on the same operands
        load(3'd1, 8'd50); load(3'd2, 8'd80);
        issue(4'd5, 3'd1, 3'd2, 1'b0, 8'd0, 3'd5, 1'b1, w); idle(2);
        issue(4'd4, 3'd1, 3'd2, 1'b0, 8'd0, 3'd6, 1'b1, w); idle(2);
        // Immediate operand
        load(3'd0, 8'h3C);
        issue(4'd0, 3'd0, 3'd1, 1'b1, 8'h0F, 3'd7, 1'b1, w); idle(2);
        // Back-to-back with valid held: second reads the freshly written r4
        issue(4'd9, 3'd1, 3'd2, 1'b0, 8'd0, 3'd4, 1'b1, w);
        issue(4'd8, 3'd4, 3'd0, 1'b0, 8'd0, 3'd5, 1'b1, w);
        check("b2b_spacing", w, 2);
        idle(3);
        // Illegal opcode: no write-back
        issue(4'd7, 3'd1, 3'd2, 1'b0, 8'd0, 3'd2, 1'b1, w); idle(2);
        // Same-edge load and write-back to r3
        issue(4'd2, 3'd1, 3'd2, 1'b0, 8'd0, 3'd3, 1'b1, w);
        cmd_valid = 1'b0;
        step(hs);
        ld_en = 1'b1; ld_addr = 3'd3; ld_data = 8'h11;
        step(hs);
        idle(2);
        readback_all();

        for (int i = 0; i < 400; i++) begin
            cmd_valid   = ($urandom_range(0, 9) < 7);
            cmd_op      = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                      : legal_ops[$urandom_range(0, 7)];
            cmd_src_a   = 3'($urandom);
            cmd_src_b   = 3'($urandom);
            cmd_imm_sel = 1'($urandom);
            cmd_imm     = 8'($urandom);
            cmd_dst     = 3'($urandom);
            cmd_wb_en   = ($urandom_range(0, 3) != 0);
            ld_en       = ($urandom_range(0, 9) < 3);
            ld_addr     = 3'($urandom);
            ld_data     = 8'($urandom);
            step(hs);
        end
        idle(3);
        readback_all();

        // Reset in the middle of EXEC aborts the command and clears the file
        issue(4'd2, 3'd1, 3'd2, 1'b0, 8'd0, 3'd6, 1'b1, w);
        cmd_valid = 1'b0;
        #1 reset = 1'b0;
        #1;
        check("mid_reset_res", {res_valid, res_data, res_wdata, res_dst, res_illegal, busy}, 0);
        check("mid_reset_alu", {alu_enable, alu_input_select, alu_selector,
                                alu_data_1, alu_data_2, alu_content}, 0);
        q.delete();
        exec_v = 0;
        wb_v = 0;
        for (int i = 0; i < 8; i++) mreg[i] = 8'd0;
        #20 reset = 1'b1;
        #1 check("ready_after_reset", cmd_ready, 1);
        @(posedge clk); #1;
        idle(2);
        readback_all();
        idle(3);
        check("scoreboard_drain", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
